bn_backward_serial: RTL and testbench

BN_BACKWARD_SERIAL -- requirements
Module: bn_backward_serial

---
 rtl/bn_pkg.sv | 43 ++++
 rtl/bn_backward_serial_if.sv | 41 ++++
 rtl/bn_fx_mac.sv | 21 ++
 rtl/bn_backward_serial.sv | 185 ++++++++++++++++++
 tb/tb_bn_backward_serial.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bn_pkg.sv
// bn_pkg -- shared definitions for the serial batch-norm backward pass.
//   BN_IL / BN_FL : default integer / fraction bits of the signed fixed-point format
//   bn_state_e    : FSM state encoding (IDLE=0 .. DONE=4), also driven on the state output
//   fx_mul        : signed product arithmetic-shifted right by the fraction width (floor)
//   fx_narrow     : narrowing to a w-bit signed range, returned sign-extended to 64 bits
// Build option: define BN_BWD_SAT_EN to saturate on narrowing; otherwise narrowing wraps.
package bn_pkg;

    localparam int unsigned BN_IL = 4;
    localparam int unsigned BN_FL = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_SCALE = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } bn_state_e;

    // Operands arrive sign-extended to 64 bits; callers keep width(a)+width(b) <= 64.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        fl);
        return (a * b) >>> fl;
    endfunction

    function automatic logic signed [63:0] fx_narrow(input logic signed [63:0] v,
                                                    input int unsigned        w);
`ifdef BN_BWD_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        // Drop the upper bits, then sign-extend from bit w-1.
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/bn_backward_serial_if.sv
// bn_backward_serial_if -- operand, result and dx-stream bundle of bn_backward_serial.
//   master : input_ready, dout[SIZE], norm[SIZE], num, gamma, std_inv, num_inv,
//            dx_ready, output_taken driven; dx, dx_idx, dx_valid, dgamma, dbeta,
//            state, done observed
//   slave  : the mirror image (used by the design)
interface bn_backward_serial_if #(
    parameter int IL   = bn_pkg::BN_IL,
    parameter int FL   = bn_pkg::BN_FL,
    parameter int SIZE = 16
);
    localparam int W  = IL + FL;
    localparam int AW = $clog2(SIZE);

    logic                input_ready;
    logic signed [W-1:0] dout [SIZE];
    logic signed [W-1:0] norm [SIZE];
    logic [AW:0]         num;
    logic signed [W-1:0] gamma;
    logic signed [W-1:0] std_inv;
    logic signed [W-1:0] num_inv;
    logic signed [W-1:0] dx;
    logic [AW-1:0]       dx_idx;
    logic                dx_valid;
    logic                dx_ready;
    logic signed [W-1:0] dgamma;
    logic signed [W-1:0] dbeta;
    logic                output_taken;
    logic [2:0]          state;
    logic                done;

    modport master (
        output input_ready, dout, norm, num, gamma, std_inv, num_inv, dx_ready, output_taken,
        input  dx, dx_idx, dx_valid, dgamma, dbeta, state, done
    );

    modport slave (
        input  input_ready, dout, norm, num, gamma, std_inv, num_inv, dx_ready, output_taken,
        output dx, dx_idx, dx_valid, dgamma, dbeta, state, done
    );

endinterface

// File: rtl/bn_fx_mac.sv
// bn_fx_mac -- combinational fixed-point multiply: y = narrow((a*b) >>> FL).
//   a_i : A_W-bit signed operand
//   b_i : B_W-bit signed operand
//   y_o : W-bit signed result
// Build option: BN_BWD_SAT_EN selects saturating narrowing (see bn_pkg::fx_narrow).
module bn_fx_mac import bn_pkg::*; #(
    parameter int A_W = 20,
    parameter int B_W = 20,
    parameter int FL  = BN_FL,
    parameter int W   = 20
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic signed [W-1:0]   y_o
);

    always_comb begin
        y_o = W'(fx_narrow(fx_mul(64'(a_i), 64'(b_i), FL), W));
    end

endmodule

// File: rtl/bn_backward_serial.sv
// bn_backward_serial -- serial batch-norm backward pass over up to SIZE elements.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : bn_backward_serial_if.slave
//           in : input_ready, dout[], norm[], num, gamma, std_inv, num_inv,
//                dx_ready, output_taken
//           out: dx, dx_idx, dx_valid (stream), dgamma, dbeta, state, done
// Flow: IDLE captures operands, ACCUM reduces one element per cycle into dbeta and
// dgamma, SCALE forms k = gamma*std_inv*num_inv and the first dx, EMIT streams dx
// beats in index order, DONE holds the reductions until output_taken.
// Build option: BN_BWD_SAT_EN makes every narrowing to W bits saturate.
module bn_backward_serial import bn_pkg::*; #(
    parameter int IL   = BN_IL,
    parameter int FL   = BN_FL,
    parameter int SIZE = 16
) (
    input logic                  clk,
    input logic                  reset,
    bn_backward_serial_if.slave  bus
);

    localparam int W  = IL + FL;
    localparam int AW = $clog2(SIZE);
    localparam int SW = W + AW + 1;

    bn_state_e           state_q;
    logic signed [W-1:0] dout_q [SIZE];
    logic signed [W-1:0] norm_q [SIZE];
    logic signed [W-1:0] gamma_q;
    logic signed [W-1:0] std_inv_q;
    logic signed [W-1:0] num_inv_q;
    logic signed [W-1:0] k_q;
    logic [AW:0]         n_q;
    logic [AW:0]         cnt_q;
    logic [AW-1:0]       dx_idx_q;
    logic signed [W-1:0] dx_q;
    logic                dx_valid_q;
    logic signed [W-1:0] dgamma_q;
    logic signed [W-1:0] dbeta_q;
    logic                done_q;

    logic [AW:0]         n_cap;
    logic [AW-1:0]       e_idx;
    logic [AW-1:0]       elem_idx;
    logic signed [W-1:0] dout_e;
    logic signed [W-1:0] norm_e;
    logic signed [W-1:0] mac_a;
    logic signed [W-1:0] mac_y;
    logic signed [W-1:0] g1;
    logic signed [W-1:0] k_comb;
    logic signed [W-1:0] k_sel;
    logic signed [W-1:0] dx_d;
    logic signed [W-1:0] dbeta_d;
    logic signed [W-1:0] dgamma_d;
    logic signed [SW-1:0] nd;
    logic signed [SW-1:0] sum_e;
    logic                last_beat;

    always_comb begin
        n_cap = (bus.num > (AW+1)'(SIZE)) ? (AW+1)'(SIZE) : bus.num;

        // SCALE prepares beat 0; in EMIT the datapath works one index ahead so the
        // next beat is ready to load the moment the current one is accepted.
        e_idx    = (state_q == ST_SCALE) ? '0 : dx_idx_q + AW'(1);
        elem_idx = (state_q == ST_ACCUM) ? cnt_q[AW-1:0] : e_idx;
        dout_e   = dout_q[elem_idx];
        norm_e   = norm_q[elem_idx];

        // Shared multiplier: dout*norm while accumulating, norm*dgamma afterwards.
        mac_a    = (state_q == ST_ACCUM) ? dout_e : dgamma_q;

        dbeta_d  = W'(fx_narrow(64'(dbeta_q) + 64'(dout_e), W));
        dgamma_d = W'(fx_narrow(64'(dgamma_q) + 64'(mac_y), W));

        // k_q is only loaded at the end of SCALE, so SCALE uses the live value.
        k_sel    = (state_q == ST_SCALE) ? k_comb : k_q;

        nd       = SW'(dout_e) * SW'($signed({1'b0, n_q}));
        sum_e    = nd - SW'(dbeta_q) - SW'(mac_y);

        last_beat = ({1'b0, dx_idx_q} == (n_q - (AW+1)'(1)));
    end

    bn_fx_mac #(.A_W(W), .B_W(W),  .FL(FL), .W(W)) u_mac_elem (
        .a_i(mac_a),     .b_i(norm_e),    .y_o(mac_y)
    );
    bn_fx_mac #(.A_W(W), .B_W(W),  .FL(FL), .W(W)) u_mac_k1 (
        .a_i(gamma_q),   .b_i(std_inv_q), .y_o(g1)
    );
    bn_fx_mac #(.A_W(W), .B_W(W),  .FL(FL), .W(W)) u_mac_k2 (
        .a_i(g1),        .b_i(num_inv_q), .y_o(k_comb)
    );
    bn_fx_mac #(.A_W(W), .B_W(SW), .FL(FL), .W(W)) u_mac_dx (
        .a_i(k_sel),     .b_i(sum_e),     .y_o(dx_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < SIZE; i++) begin
                dout_q[i] <= '0;
                norm_q[i] <= '0;
            end
            gamma_q    <= '0;
            std_inv_q  <= '0;
            num_inv_q  <= '0;
            k_q        <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            dx_idx_q   <= '0;
            dx_q       <= '0;
            dx_valid_q <= 1'b0;
            dgamma_q   <= '0;
            dbeta_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.input_ready) begin
                        for (int unsigned i = 0; i < SIZE; i++) begin
                            dout_q[i] <= bus.dout[i];
                            norm_q[i] <= bus.norm[i];
                        end
                        gamma_q    <= bus.gamma;
                        std_inv_q  <= bus.std_inv;
                        num_inv_q  <= bus.num_inv;
                        n_q        <= n_cap;
                        cnt_q      <= '0;
                        dgamma_q   <= '0;
                        dbeta_q    <= '0;
                        dx_idx_q   <= '0;
                        dx_valid_q <= 1'b0;
                        if (n_cap == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    dbeta_q  <= dbeta_d;
                    dgamma_q <= dgamma_d;
                    cnt_q    <= cnt_q + (AW+1)'(1);
                    if (cnt_q == n_q - (AW+1)'(1)) state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    k_q        <= k_comb;
                    dx_q       <= dx_d;
                    dx_idx_q   <= '0;
                    dx_valid_q <= 1'b1;
                    state_q    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.dx_ready) begin
                        if (last_beat) begin
                            dx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            dx_q     <= dx_d;
                            dx_idx_q <= e_idx;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.output_taken) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dx       = dx_q;
    assign bus.dx_idx   = dx_idx_q;
    assign bus.dx_valid = dx_valid_q;
    assign bus.dgamma   = dgamma_q;
    assign bus.dbeta    = dbeta_q;
    assign bus.state    = state_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_bn_backward_serial.sv
// tb_bn_backward_serial -- directed and randomised checks of bn_backward_serial
// (IL=4, FL=16, SIZE=16; 1.0 = 0x10000). Expected dx beats are queued when an
// operation is launched and popped as the design delivers them.
module tb_bn_backward_serial;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int SIZE = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bn_backward_serial_if #(.IL(IL), .FL(FL), .SIZE(SIZE)) bus ();

    bn_backward_serial #(.IL(IL), .FL(FL), .SIZE(SIZE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [19:0] dx;
        logic [3:0]  idx;
    } beat_t;

    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       exp_q[$];
    longint      s_dout [16];
    longint      s_norm [16];
    longint      s_gamma, s_std, s_ninv;
    int          s_num;
    logic [19:0] exp_dbeta, exp_dgamma;
    bit          aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint nar(input longint v);
`ifdef BN_BWD_SAT_EN
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
`else
        longint m;
        m = v & 64'hF_FFFF;
        if (m >= 524288) m = m - 1048576;
        return m;
`endif
    endfunction

    function automatic longint fxm(input longint a, input longint b);
        return nar((a * b) >>> 16);
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 16; i++) begin
            s_dout[i] = 0;
            s_norm[i] = 0;
        end
        s_gamma = 0; s_std = 0; s_ninv = 0; s_num = 0;
    endtask

    task automatic load033();
        clear_stim();
        s_dout[0] = 131072;  s_dout[1] = 0;
        s_norm[0] = 32768;   s_norm[1] = -32768;
        s_gamma = 65536; s_std = 65536; s_ninv = 32768; s_num = 2;
    endtask

    task automatic ref033();
        beat_t b;
        exp_q.delete();
        b.dx = 20'h0C000; b.idx = 4'd0; exp_q.push_back(b);
        b.dx = 20'hF4000; b.idx = 4'd1; exp_q.push_back(b);
        exp_dbeta  = 20'h20000;
        exp_dgamma = 20'h10000;
    endtask

    task automatic model();
        longint db, dg, k, s;
        int     n;
        beat_t  b;
        db = 0; dg = 0;
        n = (s_num > 16) ? 16 : s_num;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            db = nar(db + s_dout[i]);
            dg = nar(dg + fxm(s_dout[i], s_norm[i]));
        end
        k = fxm(fxm(s_gamma, s_std), s_ninv);
        for (int i = 0; i < n; i++) begin
            s = longint'(n) * s_dout[i] - db - fxm(s_norm[i], dg);
            b.dx  = 20'(fxm(k, s));
            b.idx = 4'(i);
            exp_q.push_back(b);
        end
        exp_dbeta  = 20'(db);
        exp_dgamma = 20'(dg);
    endtask

    task automatic apply();
        for (int i = 0; i < 16; i++) begin
            bus.dout[i] = 20'(s_dout[i]);
            bus.norm[i] = 20'(s_norm[i]);
        end
        bus.gamma   = 20'(s_gamma);
        bus.std_inv = 20'(s_std);
        bus.num_inv = 20'(s_ninv);
        bus.num     = 5'(s_num);
    endtask

    // ready_mode: 0 = always ready, 1 = hold beat 0 for 3 cycles, 2 = random ready.
    task automatic run(input int ready_mode, input bit pulse, input int abort_beat,
                       output bit ab);
        int    cyc, beats, stall, first_valid, n, n_beats;
        bit    rdy, sent_ir, sent_ot;
        beat_t b;
        ab = 1'b0; beats = 0; stall = 0; first_valid = -1; sent_ir = 0; sent_ot = 0;
        n = (s_num > 16) ? 16 : s_num;
        n_beats = exp_q.size();
        apply();
        bus.dx_ready = 1'b0;
        bus.input_ready = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 400) begin
            bus.input_ready  = 1'b0;
            bus.output_taken = 1'b0;
            if (bus.done) break;
            if (bus.dx_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (abort_beat >= 0 && beats == abort_beat) begin
                    bus.dx_ready = 1'b0;
                    ab = 1'b1;
                    return;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'b0, bus.dx_valid}, 32'd0);
                    bus.dx_ready = 1'b1;
                end else begin
                    case (ready_mode)
                        1:       rdy = !(beats == 0 && stall < 3);
                        2:       rdy = 1'($urandom_range(1));
                        default: rdy = 1'b1;
                    endcase
                    if (!rdy) begin
                        stall++;
                        chk("hold_dx",  {12'b0, bus.dx},     {12'b0, exp_q[0].dx});
                        chk("hold_idx", {28'b0, bus.dx_idx}, {28'b0, exp_q[0].idx});
                    end
                    bus.dx_ready = rdy;
                    if (rdy) begin
                        b = exp_q.pop_front();
                        chk("dx",     {12'b0, bus.dx},     {12'b0, b.dx});
                        chk("dx_idx", {28'b0, bus.dx_idx}, {28'b0, b.idx});
                        beats++;
                    end
                end
            end else begin
                bus.dx_ready = (ready_mode != 1);
            end
            if (pulse && !sent_ir && bus.state == 3'd1) begin
                bus.input_ready = 1'b1;
                bus.num = 5'd1;
                bus.dout[0] = '0;
                sent_ir = 1'b1;
            end
            if (pulse && !sent_ot && bus.state == 3'd3) begin
                bus.output_taken = 1'b1;
                sent_ot = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.dx_ready = 1'b0;
        chk("done_reached", {31'b0, bus.done}, 32'd1);
        chk("state_done",   {29'b0, bus.state}, 32'd4);
        chk("dbeta",        {12'b0, bus.dbeta},  {12'b0, exp_dbeta});
        chk("dgamma",       {12'b0, bus.dgamma}, {12'b0, exp_dgamma});
        chk("beat_count",   beats, n_beats);
        if (n > 0) begin
            chk("first_valid_cycle", first_valid, n + 2);
        end else begin
            chk("first_valid_cycle", first_valid, -1);
            chk("done_cycle", cyc, 1);
        end
        @(posedge clk); #1;
        chk("done_held",    {31'b0, bus.done},   32'd1);
        chk("dbeta_held",   {12'b0, bus.dbeta},  {12'b0, exp_dbeta});
        chk("dgamma_held",  {12'b0, bus.dgamma}, {12'b0, exp_dgamma});
        bus.output_taken = 1'b1;
        @(posedge clk); #1;
        bus.output_taken = 1'b0;
        chk("release_state", {29'b0, bus.state}, 32'd0);
        chk("release_done",  {31'b0, bus.done},  32'd0);
    endtask

    initial begin
        bus.input_ready = 1'b0;
        bus.dx_ready = 1'b0;
        bus.output_taken = 1'b0;
        clear_stim();
        apply();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",    {29'b0, bus.state},    32'd0);
        chk("rst_dx_valid", {31'b0, bus.dx_valid}, 32'd0);
        chk("rst_done",     {31'b0, bus.done},     32'd0);
        chk("rst_dx",       {12'b0, bus.dx},       32'd0);
        chk("rst_dx_idx",   {28'b0, bus.dx_idx},   32'd0);
        chk("rst_dgamma",   {12'b0, bus.dgamma},   32'd0);
        chk("rst_dbeta",    {12'b0, bus.dbeta},    32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reference case, continuous ready.
        load033(); ref033(); run(0, 1'b0, -1, aborted);

        // Reference case with beat 0 back-pressured for three cycles.
        load033(); ref033(); run(1, 1'b0, -1, aborted);

        // Empty batch.
        load033(); s_num = 0;
        exp_q.delete(); exp_dbeta = '0; exp_dgamma = '0;
        run(0, 1'b0, -1, aborted);

        // Overflowing dbeta: 4 x 7.0.
        clear_stim();
        for (int i = 0; i < 4; i++) s_dout[i] = 458752;
        s_gamma = 65536; s_std = 65536; s_ninv = 16384; s_num = 4;
        model();
`ifdef BN_BWD_SAT_EN
        exp_dbeta = 20'h7FFFF;
`else
        exp_dbeta = 20'hC0000;
`endif
        run(0, 1'b0, -1, aborted);

        // Reset while beat 1 is presented, then a clean rerun.
        load033(); ref033(); run(0, 1'b0, 1, aborted);
        chk("abort_reached", {31'b0, aborted}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_state",    {29'b0, bus.state},    32'd0);
        chk("midrst_dx_valid", {31'b0, bus.dx_valid}, 32'd0);
        chk("midrst_done",     {31'b0, bus.done},     32'd0);
        chk("midrst_dx",       {12'b0, bus.dx},       32'd0);
        chk("midrst_dbeta",    {12'b0, bus.dbeta},    32'd0);
        chk("midrst_dgamma",   {12'b0, bus.dgamma},   32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        load033(); ref033(); run(0, 1'b0, -1, aborted);

        // input_ready during ACCUM and output_taken during EMIT must be ignored.
        load033(); ref033(); run(0, 1'b1, -1, aborted);

        // Full batch with num above SIZE, random operands and random ready.
        clear_stim();
        for (int i = 0; i < 16; i++) begin
            s_dout[i] = longint'($urandom_range(262144)) - 131072;
            s_norm[i] = longint'($urandom_range(262144)) - 131072;
        end
        s_gamma = longint'($urandom_range(131072)) - 65536;
        s_std   = longint'($urandom_range(131072));
        s_ninv  = 4096;
        s_num   = 20;
        model();
        run(2, 1'b0, -1, aborted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
